// File: rtl/sio_escape_codec.sv
// sio_escape_codec: byte-stuffing framing between the UART and sio_protocol.
// TX escapes FLAG/ESC bytes and inserts flags; RX strips escapes and reports flags.
module sio_escape_codec #(
  parameter logic [7:0] FLAG_BYTE = 8'h7E,
  parameter logic [7:0] ESC_BYTE  = 8'h7D,
  parameter logic [7:0] ESC_XOR   = 8'h20
) (
  input  logic       mclk,
  input  logic       reset,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_data_strobe,
  input  logic       tx_flag,
  output logic [7:0] rx_data,
  output logic       rx_data_strobe,
  output logic       rx_flag,
  input  logic       uart_tx_ready,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_strobe,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_strobe
);

  typedef enum logic {
    IDLE,
    ESC2
  } tx_state_t;

  tx_state_t  tx_state;
  logic [7:0] tx_pend;
  logic       rx_esc;
  logic       tx_special;
  logic       uart_free;

  assign uart_free  = uart_tx_ready && !uart_tx_strobe;
  assign tx_ready   = (tx_state == IDLE) && uart_free && !reset;
  assign tx_special = (tx_data == FLAG_BYTE) || (tx_data == ESC_BYTE);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tx_state       <= IDLE;
      tx_pend        <= 8'h00;
      uart_tx_data   <= 8'h00;
      uart_tx_strobe <= 1'b0;
    end else begin
      uart_tx_strobe <= 1'b0;
      unique case (tx_state)
        IDLE: begin
          // flag wins over a data byte offered in the same cycle
          if (tx_ready && tx_flag) begin
            uart_tx_strobe <= 1'b1;
            uart_tx_data   <= FLAG_BYTE;
          end else if (tx_ready && tx_data_strobe) begin
            uart_tx_strobe <= 1'b1;
            if (tx_special) begin
              uart_tx_data <= ESC_BYTE;
              tx_pend      <= tx_data ^ ESC_XOR;
              tx_state     <= ESC2;
            end else begin
              uart_tx_data <= tx_data;
            end
          end
        end
        ESC2: begin
          if (uart_free) begin
            uart_tx_strobe <= 1'b1;
            uart_tx_data   <= tx_pend;
            tx_state       <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      rx_esc         <= 1'b0;
      rx_data        <= 8'h00;
      rx_data_strobe <= 1'b0;
      rx_flag        <= 1'b0;
    end else begin
      rx_data_strobe <= 1'b0;
      rx_flag        <= 1'b0;
      if (uart_rx_strobe) begin
        unique case (1'b1)
          (uart_rx_data == FLAG_BYTE): begin
            rx_flag <= 1'b1;
            rx_esc  <= 1'b0;
          end
          // a second ESC is a protocol error: dropped, escape stays armed
          (uart_rx_data == ESC_BYTE): rx_esc <= 1'b1;
          default: begin
            rx_data_strobe <= 1'b1;
            rx_data        <= rx_esc ? (uart_rx_data ^ ESC_XOR)
                                     : uart_rx_data;
            rx_esc         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sio_escape_codec.sv
// tb_sio_escape_codec: directed stimulus with a queue scoreboard.
// Expected UART/RX bytes are queued at issue time and popped by a monitor.
module tb_sio_escape_codec;

  logic       mclk = 1'b0;
  logic       reset;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_data_strobe;
  logic       tx_flag;
  logic [7:0] rx_data;
  logic       rx_data_strobe;
  logic       rx_flag;
  logic       uart_tx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_strobe;
  logic [7:0] uart_rx_data;
  logic       uart_rx_strobe;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rx[$];

  always #5 mclk = ~mclk;

  sio_escape_codec dut (
    .mclk           (mclk),
    .reset          (reset),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_data_strobe (tx_data_strobe),
    .tx_flag        (tx_flag),
    .rx_data        (rx_data),
    .rx_data_strobe (rx_data_strobe),
    .rx_flag        (rx_flag),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_strobe (uart_tx_strobe),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_strobe (uart_rx_strobe)
  );

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops on every DUT output pulse
  logic prev_strobe = 1'b0;
  initial begin
    forever begin
      @(negedge mclk);
      if (uart_tx_strobe) begin
        if (exp_tx.size() == 0)
          chk("uart_tx unexpected", {1'b0, uart_tx_data}, 9'h1FF);
        else
          chk("uart_tx byte", {1'b0, uart_tx_data},
              {1'b0, exp_tx.pop_front()});
        if (prev_strobe)
          chk("uart_tx back-to-back", 9'd1, 9'd0);
      end
      prev_strobe = uart_tx_strobe;
      if (rx_flag && rx_data_strobe)
        chk("rx flag+data same cycle", 9'd1, 9'd0);
      if (rx_flag || rx_data_strobe) begin
        if (exp_rx.size() == 0)
          chk("rx unexpected", {rx_flag, rx_data}, 9'h1FF);
        else
          chk("rx output",
              rx_flag ? 9'h100 : {1'b0, rx_data},
              exp_rx.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!tx_ready && k < 50) begin
      cyc();
      k++;
    end
    chk("tx_ready wait", {8'h0, tx_ready}, 9'd1);
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    wait_ready();
    tx_data        = b;
    tx_data_strobe = 1'b1;
    tx_flag        = fl;
    cyc();
    tx_data_strobe = 1'b0;
    tx_flag        = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data   = b;
    uart_rx_strobe = 1'b1;
    cyc();
    uart_rx_strobe = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    tx_data        = 8'h00;
    tx_data_strobe = 1'b0;
    tx_flag        = 1'b0;
    uart_tx_ready  = 1'b1;
    uart_rx_data   = 8'h00;
    uart_rx_strobe = 1'b0;
    cyc(2);
    chk("reset uart_tx_data", {1'b0, uart_tx_data}, 9'h000);
    chk("reset uart_tx_strobe", {8'h0, uart_tx_strobe}, 9'd0);
    chk("reset rx outputs",
        {rx_flag, rx_data_strobe, rx_data[6:0]}, 9'd0);
    chk("reset tx_ready", {8'h0, tx_ready}, 9'd0);
    reset = 1'b0;
    #1;
    chk("tx_ready after reset", {8'h0, tx_ready}, 9'd1);

    // plain byte
    exp_tx.push_back(8'h41);
    send(8'h41, 1'b0);
    chk("tx_ready low in strobe", {8'h0, tx_ready}, 9'd0);
    cyc(2);

    // escaped flag byte, UART busy after first byte
    exp_tx.push_back(8'h7D);
    exp_tx.push_back(8'h5E);
    send(8'h7E, 1'b0);
    uart_tx_ready = 1'b0;
    cyc(3);
    chk("tx_ready low in ESC2", {8'h0, tx_ready}, 9'd0);
    chk("ESC2 waits for uart", {8'h0, uart_tx_strobe}, 9'd0);
    uart_tx_ready = 1'b1;
    cyc();
    chk("second byte strobe", {8'h0, uart_tx_strobe}, 9'd1);
    chk("tx_ready low 2nd strobe", {8'h0, tx_ready}, 9'd0);
    cyc();
    chk("tx_ready back idle", {8'h0, tx_ready}, 9'd1);

    // flag and data together: only the flag goes out
    exp_tx.push_back(8'h7E);
    send(8'h7D, 1'b1);
    cyc(4);

    // RX streams
    exp_rx.push_back(9'h100);
    exp_rx.push_back(9'h010);
    exp_rx.push_back(9'h07D);
    exp_rx.push_back(9'h07E);
    exp_rx.push_back(9'h022);
    foreach (exp_rx[i]) ;
    begin
      logic [7:0] s1 [7] = '{8'h7E, 8'h10, 8'h7D, 8'h5D,
                             8'h7D, 8'h5E, 8'h22};
      for (int i = 0; i < 7; i++) rx_byte(s1[i]);
    end
    cyc(2);
    exp_rx.push_back(9'h100);
    exp_rx.push_back(9'h033);
    rx_byte(8'h7D);
    rx_byte(8'h7E);
    rx_byte(8'h33);
    cyc(2);
    exp_rx.push_back(9'h07E);
    rx_byte(8'h7D);
    rx_byte(8'h7D);
    rx_byte(8'h5E);
    cyc(3);
    chk("rx_data holds", {1'b0, rx_data}, 9'h07E);

    // reset in ESC2 drops the second half of the pair
    exp_tx.push_back(8'h7D);
    send(8'h7D, 1'b0);
    uart_tx_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc(2);
    chk("strobe low in reset", {8'h0, uart_tx_strobe}, 9'd0);
    reset = 1'b0;
    cyc(2);
    chk("tx_ready needs uart", {8'h0, tx_ready}, 9'd0);
    uart_tx_ready = 1'b1;
    #1;
    chk("tx_ready after uart", {8'h0, tx_ready}, 9'd1);
    exp_tx.push_back(8'h01);
    send(8'h01, 1'b0);
    cyc(5);

    chk("tx queue drained", 9'(exp_tx.size()), 9'd0);
    chk("rx queue drained", 9'(exp_rx.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
